// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - two-entry elastic pipeline register (main + skid) with flush
// Every output comes straight from the main register; in_ready depends only on state and rst.
module pipe_stage_skid #(
    parameter int CTRL_W = 2,
    parameter int DATA_W = 32,
    parameter int NCH    = 2,
    parameter int TAG_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_W-1:0]     in_ctrl,
    input  logic [NCH*DATA_W-1:0] in_data,
    input  logic [TAG_W-1:0]      in_tag,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_W-1:0]     out_ctrl,
    output logic [NCH*DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]      out_tag
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                state;
    logic [CTRL_W-1:0]     main_ctrl;
    logic [NCH*DATA_W-1:0] main_data;
    logic [TAG_W-1:0]      main_tag;
    logic [CTRL_W-1:0]     skid_ctrl;
    logic [NCH*DATA_W-1:0] skid_data;
    logic [TAG_W-1:0]      skid_tag;

    logic in_xfer;
    logic out_xfer;

    assign in_ready  = rst && (state != TWO);
    assign out_valid = (state != EMPTY);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    // Bubbles carry no control side effects; data and tag keep their last value.
    assign out_ctrl = out_valid ? main_ctrl : '0;
    assign out_data = main_data;
    assign out_tag  = main_tag;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= EMPTY;
            main_ctrl <= '0;
            main_data <= '0;
            main_tag  <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
            skid_tag  <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                        main_tag  <= in_tag;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                        main_tag  <= in_tag;
                    end else if (in_xfer) begin
                        skid_ctrl <= in_ctrl;
                        skid_data <= in_data;
                        skid_tag  <= in_tag;
                        state     <= TWO;
                    end else if (out_xfer) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        main_ctrl <= skid_ctrl;
                        main_data <= skid_data;
                        main_tag  <= skid_tag;
                        state     <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - scoreboard bench for pipe_stage_skid (NCH=2, NCH=4, NCH=1 instances)
module tb_pipe_stage_skid;

    typedef struct packed {
        logic [1:0]  ctrl;
        logic [63:0] data;
        logic [4:0]  tag;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  in_ctrl = '0;
    logic [63:0] in_data = '0;
    logic [4:0]  in_tag = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b, in_ready_c, out_valid_c;
    logic [1:0]  out_ctrl_a, out_ctrl_b, out_ctrl_c;
    logic [63:0] out_data_a, out_data_b;
    logic [15:0] out_data_c;
    logic [4:0]  out_tag_a, out_tag_b, out_tag_c;

    int checks = 0;
    int failures = 0;
    int cnt = 0;
    bit mon_en = 1'b0;
    ent_t sb[$];

    always #5 clk = ~clk;

    pipe_stage_skid #(.CTRL_W(2), .DATA_W(32), .NCH(2), .TAG_W(5)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_ctrl(in_ctrl), .in_data(in_data), .in_tag(in_tag), .flush(flush),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_ctrl(out_ctrl_a),
        .out_data(out_data_a), .out_tag(out_tag_a)
    );

    pipe_stage_skid #(.CTRL_W(2), .DATA_W(16), .NCH(4), .TAG_W(5)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_ctrl(in_ctrl), .in_data(in_data), .in_tag(in_tag), .flush(flush),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_ctrl(out_ctrl_b),
        .out_data(out_data_b), .out_tag(out_tag_b)
    );

    pipe_stage_skid #(.CTRL_W(2), .DATA_W(16), .NCH(1), .TAG_W(5)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c),
        .in_ctrl(in_ctrl), .in_data(in_data[15:0]), .in_tag(in_tag), .flush(flush),
        .out_valid(out_valid_c), .out_ready(out_ready), .out_ctrl(out_ctrl_c),
        .out_data(out_data_c), .out_tag(out_tag_c)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ent_t mk(input logic [1:0] c, input logic [63:0] d, input logic [4:0] t);
        ent_t e;
        e.ctrl = c;
        e.data = d;
        e.tag  = t;
        return e;
    endfunction

    // One clock of stimulus; the expected occupancy model decides acceptance.
    task automatic cycle(input bit iv, input ent_t e, input bit ordy, input bit fl);
        bit acc;
        bit oxf;
        in_valid  = iv;
        in_ctrl   = e.ctrl;
        in_data   = e.data;
        in_tag    = e.tag;
        out_ready = ordy;
        flush     = fl;
        #1;
        chk("in_ready_a", 64'(in_ready_a), 64'(rst && cnt < 2));
        chk("in_ready_c", 64'(in_ready_c), 64'(rst && cnt < 2));
        @(posedge clk);
        if (!rst || fl) begin
            cnt = 0;
            sb.delete();
        end else begin
            acc = iv && (cnt < 2);
            oxf = ordy && (cnt > 0);
            if (acc) sb.push_back(e);
            cnt = cnt + int'(acc) - int'(oxf);
        end
        #1;
    endtask

    // Monitor: pops the expected head whenever the outputs present a transfer.
    logic        prev_stall = 1'b0;
    logic [1:0]  prev_ctrl;
    logic [63:0] prev_data;
    logic [4:0]  prev_tag;

    always @(negedge clk) begin
        ent_t h;
        if (mon_en) begin
            chk("out_valid_a", 64'(out_valid_a), 64'(sb.size() != 0));
            chk("out_valid_b", 64'(out_valid_b), 64'(sb.size() != 0));
            chk("out_valid_c", 64'(out_valid_c), 64'(sb.size() != 0));
            if (!out_valid_a) chk("bubble_ctrl_a", 64'(out_ctrl_a), 64'd0);
            if (!out_valid_c) chk("bubble_ctrl_c", 64'(out_ctrl_c), 64'd0);
            if (prev_stall && out_valid_a) begin
                chk("stall_ctrl", 64'(out_ctrl_a), 64'(prev_ctrl));
                chk("stall_data", out_data_a, prev_data);
                chk("stall_tag", 64'(out_tag_a), 64'(prev_tag));
            end
            if (out_valid_a && out_ready && sb.size() != 0) begin
                h = sb.pop_front();
                chk("out_ctrl_a", 64'(out_ctrl_a), 64'(h.ctrl));
                chk("out_data_a", out_data_a, h.data);
                chk("out_tag_a", 64'(out_tag_a), 64'(h.tag));
                chk("out_data_b", out_data_b, h.data);
                chk("out_tag_b", 64'(out_tag_b), 64'(h.tag));
                chk("out_ctrl_c", 64'(out_ctrl_c), 64'(h.ctrl));
                chk("out_data_c", 64'(out_data_c), 64'(h.data[15:0]));
            end
            prev_stall = out_valid_a && !out_ready;
            prev_ctrl  = out_ctrl_a;
            prev_data  = out_data_a;
            prev_tag   = out_tag_a;
        end
    end

    initial begin
        ent_t z;
        ent_t e;
        logic [4:0] held_tag;
        z = mk(2'b00, 64'd0, 5'd0);

        // Reset state
        rst = 1'b0;
        cycle(0, z, 0, 0);
        cycle(0, z, 0, 0);
        chk("rst_out_valid", 64'(out_valid_a), 64'd0);
        chk("rst_out_ctrl", 64'(out_ctrl_a), 64'd0);
        chk("rst_out_data", out_data_a, 64'd0);
        chk("rst_out_tag", 64'(out_tag_a), 64'd0);
        chk("rst_out_data_c", 64'(out_data_c), 64'd0);
        rst = 1'b1;
        mon_en = 1'b1;

        // Single entry, one-cycle latency
        cycle(1, mk(2'b11, {32'hA, 32'hB}, 5'd7), 1, 0);
        chk("lat1_valid", 64'(out_valid_a), 64'd1);
        chk("lat1_data", out_data_a, {32'hA, 32'hB});
        cycle(0, z, 1, 0);

        // Stall: E1 main, E2 skid, E3 held upstream until drain begins
        cycle(1, mk(2'b01, 64'h1111, 5'd1), 0, 0);
        cycle(1, mk(2'b10, 64'h2222, 5'd2), 0, 0);
        cycle(1, mk(2'b11, 64'h3333, 5'd3), 0, 0);
        chk("full_in_ready", 64'(in_ready_a), 64'd0);
        cycle(1, mk(2'b11, 64'h3333, 5'd3), 1, 0);
        cycle(0, z, 1, 0);
        cycle(0, z, 1, 0);
        cycle(0, z, 1, 0);

        // 100-entry back-to-back stream
        for (int i = 0; i < 100; i++)
            cycle(1, mk(2'(i), 64'h5000 + 64'(i), 5'(i)), 1, 0);
        cycle(0, z, 1, 0);
        cycle(0, z, 1, 0);

        // Flush from TWO with E4 presented
        cycle(1, mk(2'b01, 64'hF1, 5'd11), 0, 0);
        cycle(1, mk(2'b10, 64'hF2, 5'd12), 0, 0);
        held_tag = 5'd11;
        cycle(1, mk(2'b11, 64'hE4, 5'd4), 0, 1);
        chk("flush_valid", 64'(out_valid_a), 64'd0);
        chk("flush_ctrl", 64'(out_ctrl_a), 64'd0);
        chk("flush_in_ready", 64'(in_ready_a), 64'd1);
        chk("flush_keeps_tag", 64'(out_tag_a), 64'(held_tag));
        cycle(0, z, 1, 0);

        // Reset from TWO
        cycle(1, mk(2'b01, 64'hA1, 5'd21), 0, 0);
        cycle(1, mk(2'b10, 64'hA2, 5'd22), 0, 0);
        rst = 1'b0;
        cycle(1, mk(2'b11, 64'hA3, 5'd23), 1, 1);
        chk("midrst_valid", 64'(out_valid_a), 64'd0);
        chk("midrst_data", out_data_a, 64'd0);
        chk("midrst_tag", 64'(out_tag_a), 64'd0);
        rst = 1'b1;
        cycle(1, mk(2'b10, 64'hB1, 5'd25), 0, 0);
        chk("postrst_data", out_data_a, 64'hB1);
        cycle(0, z, 1, 0);

        // Pseudo-random traffic
        for (int i = 0; i < 400; i++) begin
            e = mk(2'($urandom), {$urandom, $urandom}, 5'($urandom));
            cycle(1'($urandom_range(0, 1)), e, ($urandom % 4) != 0, ($urandom % 16) == 0);
        end
        cycle(0, z, 1, 0);
        cycle(0, z, 1, 0);
        chk("drain_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
